// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter for fetch, execute and a sprite-page DMA engine.
// Define DMA_ALIGN_EN to align DMA starts to even cycles with a parity register.
module mem_bus_arbiter #(
  parameter int                   REG_WIDTH  = 8,
  parameter int                   ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] DMA_DEST  = 16'h2004,
  parameter int                   DMA_LEN    = 256
) (
  input  logic                  phi1,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  input  logic                  exec_req,
  input  logic                  exec_we,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [REG_WIDTH-1:0]  exec_wdata,
  output logic                  exec_gnt,
  output logic                  exec_rvalid,
  input  logic                  dma_start,
  input  logic [REG_WIDTH-1:0]  dma_page,
  output logic                  dma_busy,
  output logic                  cpu_rdy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic [REG_WIDTH-1:0]  rdata
);

  // Handshake: a requester holds req (and its address/data) until it sees a
  // one-cycle gnt; the access is on mem_* in the gnt cycle, and for reads the
  // matching rvalid pulses one cycle later with rdata.

  typedef enum logic [1:0] {
    IDLE,
    DMA_RD,
    DMA_WR
`ifdef DMA_ALIGN_EN
    , DMA_ALIGN
`endif
  } state_t;

  localparam logic [7:0] IDX_LAST = 8'(DMA_LEN - 1);

  state_t                  state_q, state_d;
  logic [REG_WIDTH-1:0]    page_q, page_d;
  logic [7:0]              idx_q, idx_d;
  logic                    fetch_gnt_q, fetch_gnt_d;
  logic                    exec_gnt_q, exec_gnt_d;
  logic                    fetch_rvalid_q, fetch_rvalid_d;
  logic                    exec_rvalid_q, exec_rvalid_d;
  logic                    fetch_pend_q, fetch_pend_d;
  logic                    exec_pend_q, exec_pend_d;
  logic                    dma_busy_q, dma_busy_d;
  logic                    cpu_rdy_q, cpu_rdy_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [REG_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [REG_WIDTH-1:0]    rdata_q, rdata_d;

`ifdef DMA_ALIGN_EN
  logic parity_q;

  always_ff @(posedge phi1) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= ~parity_q;
  end
`endif

  always_comb begin
    state_d        = state_q;
    page_d         = page_q;
    idx_d          = idx_q;
    fetch_gnt_d    = 1'b0;
    exec_gnt_d     = 1'b0;
    fetch_pend_d   = 1'b0;
    exec_pend_d    = 1'b0;
    // Read data returns one cycle after the grant regardless of DMA start.
    fetch_rvalid_d = fetch_pend_q;
    exec_rvalid_d  = exec_pend_q;
    rdata_d        = (fetch_pend_q || exec_pend_q) ? mem_rdata : rdata_q;
    dma_busy_d     = dma_busy_q;
    cpu_rdy_d      = cpu_rdy_q;
    mem_en_d       = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (dma_start) begin
          page_d     = dma_page;
          idx_d      = 8'd0;
          dma_busy_d = 1'b1;
          cpu_rdy_d  = 1'b0;
`ifdef DMA_ALIGN_EN
          if (parity_q) begin
            state_d = DMA_ALIGN;
          end else begin
            state_d    = DMA_RD;
            mem_en_d   = 1'b1;
            mem_addr_d = ADDR_WIDTH'({dma_page, 8'd0});
          end
`else
          state_d    = DMA_RD;
          mem_en_d   = 1'b1;
          mem_addr_d = ADDR_WIDTH'({dma_page, 8'd0});
`endif
        end else if (exec_req) begin
          exec_gnt_d  = 1'b1;
          exec_pend_d = ~exec_we;
          mem_en_d    = 1'b1;
          mem_we_d    = exec_we;
          mem_addr_d  = exec_addr;
          if (exec_we) mem_wdata_d = exec_wdata;
        end else if (fetch_req) begin
          fetch_gnt_d  = 1'b1;
          fetch_pend_d = 1'b1;
          mem_en_d     = 1'b1;
          mem_addr_d   = fetch_addr;
        end
      end
`ifdef DMA_ALIGN_EN
      DMA_ALIGN: begin
        state_d    = DMA_RD;
        mem_en_d   = 1'b1;
        mem_addr_d = ADDR_WIDTH'({page_q, idx_q});
      end
`endif
      DMA_RD: begin
        state_d     = DMA_WR;
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = DMA_DEST;
        mem_wdata_d = mem_rdata;
      end
      DMA_WR: begin
        idx_d = idx_q + 8'd1;
        if (idx_q == IDX_LAST) begin
          state_d    = IDLE;
          dma_busy_d = 1'b0;
          cpu_rdy_d  = 1'b1;
        end else begin
          state_d    = DMA_RD;
          mem_en_d   = 1'b1;
          mem_addr_d = ADDR_WIDTH'({page_q, idx_q + 8'd1});
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge phi1) begin
    if (reset) begin
      state_q        <= IDLE;
      page_q         <= '0;
      idx_q          <= 8'd0;
      fetch_gnt_q    <= 1'b0;
      exec_gnt_q     <= 1'b0;
      fetch_rvalid_q <= 1'b0;
      exec_rvalid_q  <= 1'b0;
      fetch_pend_q   <= 1'b0;
      exec_pend_q    <= 1'b0;
      dma_busy_q     <= 1'b0;
      cpu_rdy_q      <= 1'b1;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      page_q         <= page_d;
      idx_q          <= idx_d;
      fetch_gnt_q    <= fetch_gnt_d;
      exec_gnt_q     <= exec_gnt_d;
      fetch_rvalid_q <= fetch_rvalid_d;
      exec_rvalid_q  <= exec_rvalid_d;
      fetch_pend_q   <= fetch_pend_d;
      exec_pend_q    <= exec_pend_d;
      dma_busy_q     <= dma_busy_d;
      cpu_rdy_q      <= cpu_rdy_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rdata_q        <= rdata_d;
    end
  end

  assign fetch_gnt    = fetch_gnt_q;
  assign exec_gnt     = exec_gnt_q;
  assign fetch_rvalid = fetch_rvalid_q;
  assign exec_rvalid  = exec_rvalid_q;
  assign dma_busy     = dma_busy_q;
  assign cpu_rdy      = cpu_rdy_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign rdata        = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: CPU arbitration, read return, DMA copy,
// reset abort; DMA length expectations follow DMA_ALIGN_EN when defined.
module tb_mem_bus_arbiter;

  logic        phi1;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic        exec_req;
  logic        exec_we;
  logic [15:0] exec_addr;
  logic [7:0]  exec_wdata;
  logic        exec_gnt;
  logic        exec_rvalid;
  logic        dma_start;
  logic [7:0]  dma_page;
  logic        dma_busy;
  logic        cpu_rdy;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  rdata;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  mem_bus_arbiter dut (
    .phi1         (phi1),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .exec_req     (exec_req),
    .exec_we      (exec_we),
    .exec_addr    (exec_addr),
    .exec_wdata   (exec_wdata),
    .exec_gnt     (exec_gnt),
    .exec_rvalid  (exec_rvalid),
    .dma_start    (dma_start),
    .dma_page     (dma_page),
    .dma_busy     (dma_busy),
    .cpu_rdy      (cpu_rdy),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .rdata        (rdata)
  );

  // clock / reset-time memory model
  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  logic [7:0] mem [0:65535];
  assign mem_rdata = mem[mem_addr];

  always @(posedge phi1) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[16'h0300 + i] <= 8'(i) ^ 8'hFF;
      mem[16'h8000] <= 8'hA9;
      mem[16'h0010] <= 8'h3C;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

`ifdef DMA_ALIGN_EN
  int cyc;
  always @(posedge phi1) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end
`endif

  // driver / checker tasks
  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Starts a DMA from page 03 and checks the whole transfer; a second
  // dma_start (page 05) is injected mid-transfer and must be ignored.
  task automatic dma_run(input string tag);
    int busy_n;
    int wr_n;
    int bad;
    int exp_len;
    bit par;
    logic [7:0] exp_d;
    par = 1'b0;
`ifdef DMA_ALIGN_EN
    par = cyc[0];
`endif
    exp_len = 512 + int'(par);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ 8'hFF);
    dma_start = 1'b1;
    dma_page  = 8'h03;
    tick();
    dma_start = 1'b0;
    check({tag, "_start_busy"}, 32'(dma_busy), 32'd1);
    check({tag, "_start_rdy"}, 32'(cpu_rdy), 32'd0);
    check({tag, "_start_gnt"}, 32'({fetch_gnt, exec_gnt}), 32'd0);
    check({tag, "_start_en"}, 32'(mem_en), par ? 32'd0 : 32'd1);
    if (!par) check({tag, "_start_addr"}, 32'(mem_addr), 32'h0300);
    busy_n = 1;
    wr_n   = 0;
    bad    = 0;
    for (int c = 0; c < 1200 && dma_busy; c++) begin
      dma_start = (c == 100);
      dma_page  = (c == 100) ? 8'h05 : 8'h03;
      tick();
      if (mem_en && mem_we) begin
        wr_n++;
        exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        check({tag, "_wdata"}, 32'(mem_wdata), 32'(exp_d));
        if (mem_addr != 16'h2004) bad++;
      end
      if (dma_busy) begin
        busy_n++;
        if (cpu_rdy || fetch_gnt || exec_gnt || fetch_rvalid || exec_rvalid) bad++;
      end
    end
    dma_start = 1'b0;
    check({tag, "_busy_len"}, 32'(busy_n), 32'(exp_len));
    check({tag, "_writes"}, 32'(wr_n), 32'd256);
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_violations"}, 32'(bad), 32'd0);
    check({tag, "_end_rdy"}, 32'(cpu_rdy), 32'd1);
    check({tag, "_end_en"}, 32'(mem_en), 32'd0);
    check({tag, "_end_gnt"}, 32'({fetch_gnt, exec_gnt}), 32'd0);
  endtask

  initial begin
    int wr_n;
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = 16'h0000;
    exec_req   = 1'b0;
    exec_we    = 1'b0;
    exec_addr  = 16'h0000;
    exec_wdata = 8'h00;
    dma_start  = 1'b0;
    dma_page   = 8'h00;
    tick();
    tick();
    check("rst_gnt", 32'({fetch_gnt, exec_gnt}), 32'd0);
    check("rst_rvalid", 32'({fetch_rvalid, exec_rvalid}), 32'd0);
    check("rst_mem_en_we", 32'({mem_en, mem_we}), 32'd0);
    check("rst_busy", 32'(dma_busy), 32'd0);
    check("rst_rdy", 32'(cpu_rdy), 32'd1);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata_rdata", 32'({mem_wdata, rdata}), 32'd0);

    // single fetch read
    reset      = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 16'h8000;
    tick();
    check("f_gnt", 32'(fetch_gnt), 32'd1);
    check("f_en_we", 32'({mem_en, mem_we}), 32'b10);
    check("f_addr", 32'(mem_addr), 32'h8000);
    check("f_rvalid_early", 32'(fetch_rvalid), 32'd0);
    fetch_req = 1'b0;
    tick();
    check("f_rvalid", 32'(fetch_rvalid), 32'd1);
    check("f_rdata", 32'(rdata), 32'hA9);
    check("f_idle", 32'({fetch_gnt, mem_en}), 32'd0);
    tick();
    check("f_rvalid_pulse", 32'(fetch_rvalid), 32'd0);

    // exec beats fetch, both reads
    fetch_req = 1'b1;
    exec_req  = 1'b1;
    exec_we   = 1'b0;
    exec_addr = 16'h0010;
    tick();
    check("p_gnt1", 32'({exec_gnt, fetch_gnt}), 32'b10);
    check("p_addr1", 32'(mem_addr), 32'h0010);
    exec_req = 1'b0;
    tick();
    check("p_gnt2", 32'({exec_gnt, fetch_gnt}), 32'b01);
    check("p_addr2", 32'(mem_addr), 32'h8000);
    check("p_rv1", 32'({exec_rvalid, fetch_rvalid}), 32'b10);
    check("p_rdata1", 32'(rdata), 32'h3C);
    fetch_req = 1'b0;
    tick();
    check("p_rv2", 32'({exec_rvalid, fetch_rvalid}), 32'b01);
    check("p_rdata2", 32'(rdata), 32'hA9);

    // exec write
    exec_req   = 1'b1;
    exec_we    = 1'b1;
    exec_addr  = 16'h0200;
    exec_wdata = 8'h5A;
    tick();
    check("w_gnt", 32'(exec_gnt), 32'd1);
    check("w_en_we", 32'({mem_en, mem_we}), 32'b11);
    check("w_addr", 32'(mem_addr), 32'h0200);
    check("w_wdata", 32'(mem_wdata), 32'h5A);
    exec_req = 1'b0;
    exec_we  = 1'b0;
    tick();
    check("w_no_rvalid", 32'(exec_rvalid), 32'd0);
    check("w_we_pulse", 32'({mem_en, mem_we}), 32'd0);
    check("w_mem", 32'(mem[16'h0200]), 32'h5A);

    // DMA with exec read waiting behind it
    exec_req  = 1'b1;
    exec_we   = 1'b0;
    exec_addr = 16'h0010;
    dma_run("dma1");
    tick();
    check("d1_exec_gnt", 32'(exec_gnt), 32'd1);
    check("d1_exec_addr", 32'(mem_addr), 32'h0010);
    exec_req = 1'b0;
    tick();
    check("d1_exec_rvalid", 32'(exec_rvalid), 32'd1);
    check("d1_exec_rdata", 32'(rdata), 32'h3C);

    // reset in the middle of a DMA
    dma_start = 1'b1;
    dma_page  = 8'h03;
    tick();
    dma_start = 1'b0;
    wr_n = 0;
    for (int c = 0; c < 100 && wr_n < 10; c++) begin
      tick();
      if (mem_en && mem_we) wr_n++;
    end
    check("ra_writes", 32'(wr_n), 32'd10);
    reset = 1'b1;
    tick();
    check("ra_busy", 32'(dma_busy), 32'd0);
    check("ra_rdy", 32'(cpu_rdy), 32'd1);
    check("ra_en_we", 32'({mem_en, mem_we}), 32'd0);
    check("ra_addr", 32'(mem_addr), 32'd0);
    check("ra_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;
    wr_n = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (mem_en || mem_we || dma_busy) wr_n++;
    end
    check("ra_quiet", 32'(wr_n), 32'd0);

    // second complete DMA, from the opposite cycle parity when aligning
`ifdef DMA_ALIGN_EN
    if (cyc[0] == 1'b0) tick();
`endif
    dma_run("dma2");
`ifdef DMA_ALIGN_EN
    if (cyc[0] == 1'b1) tick();
    dma_run("dma3");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
